fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the asynchronous-read instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake toward decode. It supports redirects (branch/jump/trap), halt and backpressure.

---
 rtl/rv_pkg.sv | 9 +
 rtl/fetch_pc.sv | 47 ++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the RV fetch path: instruction width, NOP encoding
// and the default reset vector.
package rv_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with redirect / +4 / hold next-PC selection and the sticky
// "misaligned target already emitted" flag. Honours FETCH_MISALIGN_TRAP_EN.
module fetch_pc
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fetch,
  input  logic        i_set_stuck,
  output logic [31:0] o_pc,
  output logic        o_stuck
);

  logic [31:0] r_pc;
  logic        r_stuck;
  logic [31:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target = i_redirect_pc;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign w_target = {i_redirect_pc[31:2], 2'b00};
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= RESET_PC;
      r_stuck <= 1'b0;
    end else if (i_redirect_valid) begin
      r_pc    <= w_target;
      r_stuck <= 1'b0;
    end else if (i_fetch) begin
      r_pc <= r_pc + 32'd4;
      if (i_set_stuck) begin
        r_stuck <= 1'b1;
      end
    end
  end

  assign o_pc    = r_pc;
  assign o_stuck = r_stuck;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID output register with valid/ready toward
// decode, redirect/halt/backpressure. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [31:0]       o_imem_addr,
  input  logic [INST_W-1:0] i_imem_data,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  input  logic              i_halt,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [31:0]       o_pc,
  output logic              o_misaligned,
  output logic [31:0]       o_fetch_count
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [31:0]       r_pc;
  logic              r_misaligned;
  logic [31:0]       r_fetch_count;

  logic [31:0]       w_pc;
  logic              w_stuck;
  logic              w_adv;
  logic              w_fetch;
  logic              w_mis;
  logic              w_set_stuck;
  logic [INST_W-1:0] w_inst;

  assign w_adv   = !r_valid || i_ready;
  assign w_fetch = !i_redirect_valid && !i_halt && !w_stuck && w_adv;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_mis       = (w_pc[1:0] != 2'b00);
  assign w_set_stuck = w_fetch && w_mis;
  assign w_inst      = w_mis ? NOP_INST : i_imem_data;
`else
  assign w_mis       = 1'b0;
  assign w_set_stuck = 1'b0;
  assign w_inst      = i_imem_data;
`endif

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_fetch          (w_fetch),
    .i_set_stuck      (w_set_stuck),
    .o_pc             (w_pc),
    .o_stuck          (w_stuck)
  );

  // Memory decodes only the low IMEM_ADDR_W bits; upper bits pass through.
  assign o_imem_addr = {w_pc[31:IMEM_ADDR_W], w_pc[IMEM_ADDR_W-1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid       <= 1'b0;
      r_inst        <= NOP_INST;
      r_pc          <= RESET_PC;
      r_misaligned  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      // A transfer squashed by a simultaneous redirect is not counted.
      if (r_valid && i_ready && !i_redirect_valid) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (i_redirect_valid) begin
        r_valid <= 1'b0;
      end else if (i_halt || w_stuck) begin
        if (i_ready) begin
          r_valid <= 1'b0;
        end
      end else if (w_adv) begin
        r_valid      <= 1'b1;
        r_inst       <= w_inst;
        r_pc         <= w_pc;
        r_misaligned <= w_mis;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_inst        = r_inst;
  assign o_pc          = r_pc;
  assign o_misaligned  = r_misaligned;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then randomized traffic
// against a transaction-level model. Honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        redirValid;
  logic [31:0] redirPc;
  logic        halt;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pcOut;
  logic        misaligned;
  logic [31:0] fetchCount;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } xfer_t;

  xfer_t expQ[$];

  // Model state seen by decode during the current cycle (cur*) and after the next edge (n*).
  logic [31:0] curPc, nPc;
  logic        curValid, nValid;
  logic [31:0] curOutPc, nOutPc;
  logic [31:0] curInst, nInst;
  logic        curMis, nMis;
  logic        curStuck, nStuck;
  logic [31:0] curCount, nCount;

  fetch_stage dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .o_imem_addr      (imemAddr),
    .i_imem_data      (imemData),
    .i_redirect_valid (redirValid),
    .i_redirect_pc    (redirPc),
    .i_halt           (halt),
    .o_valid          (valid),
    .i_ready          (ready),
    .o_inst           (inst),
    .o_pc             (pcOut),
    .o_misaligned     (misaligned),
    .o_fetch_count    (fetchCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8113;
      32'h8:   return 32'h0020_8193;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imemData = memWord(imemAddr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    curPc = 32'h0; curValid = 1'b0; curOutPc = 32'h0; curInst = NOP;
    curMis = 1'b0; curStuck = 1'b0; curCount = 32'h0;
    expQ.delete();
  endtask

  // Drive one cycle of inputs, predict the outcome of the next edge, then step past it.
  task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc,
                               input bit h, input bit rd);
    rst = r; redirValid = rv; redirPc = rpc; halt = h; ready = rd;
    if (r) begin
      modelReset();
      nPc = 32'h0; nValid = 1'b0; nOutPc = 32'h0; nInst = NOP;
      nMis = 1'b0; nStuck = 1'b0; nCount = 32'h0;
    end else begin
      nPc = curPc; nValid = curValid; nOutPc = curOutPc; nInst = curInst;
      nMis = curMis; nStuck = curStuck; nCount = curCount;
      if (curValid && rd && !rv) begin
        expQ.push_back('{pc: curOutPc, inst: curInst, mis: curMis});
        nCount = curCount + 1;
      end
      if (rv) begin
        nPc = TRAP_EN ? rpc : (rpc & 32'hFFFF_FFFC);
        nValid = 1'b0;
        nStuck = 1'b0;
      end else if (h || curStuck) begin
        if (rd) nValid = 1'b0;
      end else if (!curValid || rd) begin
        nValid = 1'b1;
        nOutPc = curPc;
        nPc = curPc + 32'd4;
        if (TRAP_EN && curPc[1:0] != 2'b00) begin
          nInst = NOP; nMis = 1'b1; nStuck = 1'b1;
        end else begin
          nInst = memWord(curPc); nMis = 1'b0;
        end
      end
    end
    @(posedge clk);
    curPc = nPc; curValid = nValid; curOutPc = nOutPc; curInst = nInst;
    curMis = nMis; curStuck = nStuck; curCount = nCount;
    #1;
  endtask

  // Monitor: compares visible state and pops the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("valid", {31'b0, valid}, {31'b0, curValid});
      checkOutput("imem_addr", imemAddr, curPc);
      checkOutput("fetch_count", fetchCount, curCount);
      if (valid && ready && !redirValid && !rst) begin
        if (expQ.size() == 0) begin
          checkOutput("xfer_unexpected", pcOut, 32'hDEAD_BEEF);
        end else begin
          xfer_t e;
          e = expQ.pop_front();
          checkOutput("xfer_pc", pcOut, e.pc);
          checkOutput("xfer_inst", inst, e.inst);
          checkOutput("xfer_mis", {31'b0, misaligned}, {31'b0, e.mis});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; redirValid = 1'b0; redirPc = 32'h0; halt = 1'b0; ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, valid}, 32'h0);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_pc", pcOut, 32'h0);
    checkOutput("rst_mis", {31'b0, misaligned}, 32'h0);
    checkOutput("rst_count", fetchCount, 32'h0);
    started = 1'b1;

    // Sequential fetch, backpressure, redirect, halt.
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("seq_pc8", pcOut, 32'h8);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp_pc_stable", pcOut, 32'h8);
    repeat (2) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h100, 0, 1);
    checkOutput("redir_bubble", {31'b0, valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("redir_target", pcOut, 32'h100);
    repeat (2) applyStimulus(0, 0, 0, 1, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);

    // Wrap at the top of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_top", pcOut, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_zero", pcOut, 32'h0);

    // Misaligned redirect target.
    applyStimulus(0, 1, 32'h102, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mis_pc", pcOut, TRAP_EN ? 32'h102 : 32'h100);
    checkOutput("mis_flag", {31'b0, misaligned}, TRAP_EN ? 32'h1 : 32'h0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h200, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);

    // Randomized traffic including mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, rv, h, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 15) == 0);
      h  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 3) != 0);
      t  = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(r, rv, t, h, rd);
    end

    applyStimulus(0, 0, 0, 1, 0);
    started = 1'b0;
    checkOutput("queue_drained", expQ.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
